// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multi-cycle fetch/decode/execute control unit for the 16-bit CPU
//
// Ports:
//   clk, reset                 sole clock; synchronous active-high reset
//   run                        starts execution from IDLE
//   mem_req/we/addr/wdata      instruction and data memory request (word addressed)
//   mem_rdata, mem_ready       memory read data and transfer-complete strobe
//   rf_raddr_a/b, rf_rdata_a/b register-file read ports (rx, ry)
//   rf_we/waddr/wdata          register-file write port
//   alu_a/b, alu_op_select     ALU operands and op code; alu_result returns the result
//   pc, halted, illegal        status: current PC, HALT state, illegal-opcode pulse
module cpu_control_fsm #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [2:0]  rf_raddr_a,
  output logic [2:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op_select,
  input  logic [15:0] alu_result,
  output logic [15:0] pc,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MV   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_MVI  = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b0111;
  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_ST   = 4'b1001;
  localparam logic [3:0] OP_JR   = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [15:0] wb_q, wb_d;

  logic [3:0]  opcode;
  logic [15:0] imm9;
  logic        is_alu_op;
  logic        is_imm_op;
  logic        is_illegal;

  assign opcode     = ir_q[15:12];
  assign imm9       = {7'b0, ir_q[8:0]};
  assign is_alu_op  = (opcode >= OP_MV) && (opcode <= OP_ADDI);
  assign is_imm_op  = (opcode == OP_MVI) || (opcode == OP_ADDI);
  assign is_illegal = (opcode >= 4'b1011) && (opcode <= 4'b1110);

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADDI: alu_code = 3'b010;
      OP_XOR:          alu_code = 3'b011;
      OP_OR:           alu_code = 3'b100;
      OP_AND:          alu_code = 3'b101;
      default:         alu_code = 3'b000;  // MV and MVI use PASS_B
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      wb_q    <= wb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    wb_d    = wb_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_a_d = rf_rdata_a;
        op_b_d = is_imm_op ? imm9 : rf_rdata_b;
        if (is_alu_op) begin
          state_d = S_EXEC;
        end else begin
          case (opcode)
            OP_LD, OP_ST: state_d = S_MEM;
            OP_JR: begin
              pc_d    = rf_rdata_a;
              state_d = S_FETCH;
            end
            OP_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;  // NOP and illegal opcodes
          endcase
        end
      end
      S_EXEC: begin
        wb_d    = alu_result;
        state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_LD) begin
            wb_d    = mem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state so mem_ready never reaches an output.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    rf_we         = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    alu_a         = '0;
    alu_b         = '0;
    alu_op_select = '0;
    halted        = 1'b0;
    illegal       = 1'b0;
    rf_raddr_a    = ir_q[11:9];
    rf_raddr_b    = ir_q[8:6];
    pc            = pc_q;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      S_DECODE: illegal = is_illegal;
      S_EXEC: begin
        alu_a         = op_a_q;
        alu_b         = op_b_q;
        alu_op_select = alu_code(opcode);
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = (opcode == OP_ST);
        mem_addr  = op_b_q;
        mem_wdata = op_a_q;
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = ir_q[11:9];
        rf_wdata = wb_q;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - directed scoreboard bench for cpu_control_fsm
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr, alu_op_select;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we, halted, illegal;
  logic [15:0] alu_a, alu_b, alu_result, pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_control_fsm #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_select(alu_op_select), .alu_result(alu_result),
    .pc(pc), .halted(halted), .illegal(illegal)
  );

  // Environment models: memory with programmable wait states, register file, ALU.
  logic [15:0] mem [0:65535];
  logic [15:0] rf [0:7];
  int mem_delay = 0;
  int wait_cnt = 0;

  assign mem_ready  = mem_req && (wait_cnt >= mem_delay);
  assign mem_rdata  = mem[mem_addr];
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always_comb begin
    alu_result = 16'h0000;
    case (alu_op_select)
      3'b000: alu_result = alu_b;
      3'b010: alu_result = alu_a + alu_b;
      3'b011: alu_result = alu_a ^ alu_b;
      3'b100: alu_result = alu_a | alu_b;
      3'b101: alu_result = alu_a & alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  always @(posedge clk) begin
    if (!mem_req || mem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) mem[mem_addr] = mem_wdata;
    if (rf_we) rf[rf_waddr] = rf_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboards
  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic [2:0]  op;
  } wb_t;
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } st_t;

  wb_t         wb_q[$];
  st_t         st_q[$];
  logic [15:0] fetch_log[$];
  int          ill_cnt = 0;
  int          rf_we_cnt = 0;
  int          st_cnt = 0;

  logic [2:0]  prev_op = 3'b000;
  logic        stall_prev = 1'b0;
  logic [15:0] held_addr, held_wdata;
  logic        held_we;

  always @(negedge clk) begin
    if (rf_we) begin
      rf_we_cnt++;
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", {29'b0, rf_waddr}, 32'hFFFF_FFFF);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        chk("wb_addr", {29'b0, rf_waddr}, {29'b0, e.addr});
        chk("wb_data", {16'b0, rf_wdata}, {16'b0, e.data});
        chk("wb_alu_op", {29'b0, prev_op}, {29'b0, e.op});
      end
    end
    if (mem_req && mem_we && mem_ready) begin
      st_cnt++;
      if (st_q.size() == 0) begin
        chk("st_unexpected", {16'b0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        st_t s;
        s = st_q.pop_front();
        chk("st_addr", {16'b0, mem_addr}, {16'b0, s.addr});
        chk("st_data", {16'b0, mem_wdata}, {16'b0, s.data});
      end
    end
    if (mem_req && !mem_we && mem_ready) fetch_log.push_back(mem_addr);
    if (stall_prev && mem_req)
      chk("req_stable", {mem_addr, mem_wdata[14:0], mem_we},
          {held_addr, held_wdata[14:0], held_we});
    if (!mem_req)
      chk("mem_idle_zero", {mem_addr, mem_wdata[14:0], mem_we}, 32'h0);
    if (illegal) ill_cnt++;
    stall_prev = mem_req && !mem_ready;
    held_addr  = mem_addr;
    held_wdata = mem_wdata;
    held_we    = mem_we;
    prev_op    = alu_op_select;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    fetch_log.delete();
    ill_cnt   = 0;
    rf_we_cnt = 0;
    st_cnt    = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Leaves the bench at the negedge of the first FETCH cycle.
  task automatic start();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_halted(input int max, input string tag);
    int n = 0;
    while (!halted && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, halted}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;

    // Reset state
    do_reset();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
    chk("rst_pc", {16'b0, pc}, 32'h0000);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_alu", {alu_a[13:0], alu_b[14:0], alu_op_select}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);

    // MVI r1,#5 ; MVI r2,#3 ; ADD r1,r2 ; HALT
    mem[0] = 16'h6205; mem[1] = 16'h6403; mem[2] = 16'h2280; mem[3] = 16'hF000;
    wb_q.push_back('{3'd1, 16'h0005, 3'b000});
    wb_q.push_back('{3'd2, 16'h0003, 3'b000});
    wb_q.push_back('{3'd1, 16'h0008, 3'b010});
    start();
    chk("start_fetch_req", {31'b0, mem_req}, 32'd1);
    chk("start_fetch_addr", {16'b0, mem_addr}, 32'h0000);
    repeat (13) @(negedge clk);
    chk("halted_c13", {31'b0, halted}, 32'd0);
    @(negedge clk);
    chk("halted_c14", {31'b0, halted}, 32'd1);
    chk("halt_pc", {16'b0, pc}, 32'h0004);
    chk("prog1_wb_drained", wb_q.size(), 32'd0);
    // run in HALT has no effect
    start();
    repeat (3) @(negedge clk);
    chk("halt_stays", {31'b0, halted}, 32'd1);
    chk("halt_no_req", {31'b0, mem_req}, 32'd0);
    chk("halt_pc_hold", {16'b0, pc}, 32'h0004);

    // XOR / OR / AND / MV with rx=00F0, ry=0FF0
    do_reset();
    rf[1] = 16'h00F0; rf[2] = 16'h0FF0; rf[3] = 16'h00F0; rf[4] = 16'h00F0; rf[5] = 16'h1234;
    mem[0] = 16'h3280; mem[1] = 16'h4680; mem[2] = 16'h5880; mem[3] = 16'h1A80;
    mem[4] = 16'hF000;
    wb_q.push_back('{3'd1, 16'h0F00, 3'b011});
    wb_q.push_back('{3'd3, 16'h0FF0, 3'b100});
    wb_q.push_back('{3'd4, 16'h00F0, 3'b101});
    wb_q.push_back('{3'd5, 16'h0FF0, 3'b000});
    start();
    wait_halted(100, "logic_prog_halt");
    chk("logic_wb_drained", wb_q.size(), 32'd0);

    // ST r1->[r2] ; LD r3<-[r2] with three wait cycles on every access
    do_reset();
    mem_delay = 3;
    rf[1] = 16'hBEEF; rf[2] = 16'h0100; rf[3] = 16'h0000;
    mem[0] = 16'h9280; mem[1] = 16'h8680; mem[2] = 16'hF000;
    st_q.push_back('{16'h0100, 16'hBEEF});
    wb_q.push_back('{3'd3, 16'hBEEF, 3'b000});
    start();
    wait_halted(200, "ldst_halt");
    chk("ldst_wb_drained", wb_q.size(), 32'd0);
    chk("ldst_st_count", st_cnt, 32'd1);
    chk("ldst_mem_word", {16'b0, mem[16'h0100]}, 32'h0000_BEEF);
    chk("ldst_r3", {16'b0, rf[3]}, 32'h0000_BEEF);
    mem_delay = 0;

    // JR to FFFF, NOP there, PC wraps to 0000
    do_reset();
    rf[1] = 16'hFFFF;
    mem[0] = 16'hA200; mem[16'hFFFF] = 16'h0000;
    start();
    repeat (5) @(negedge clk);
    chk("jr_fetch_count", (fetch_log.size() >= 3), 32'd1);
    if (fetch_log.size() >= 3) begin
      chk("jr_fetch0", {16'b0, fetch_log[0]}, 32'h0000);
      chk("jr_fetch1", {16'b0, fetch_log[1]}, 32'h0000_FFFF);
      chk("jr_fetch2", {16'b0, fetch_log[2]}, 32'h0000);
    end

    // Illegal opcode 1100 behaves as NOP with a one-cycle pulse
    do_reset();
    mem[0] = 16'hC000; mem[1] = 16'hF000;
    start();
    @(negedge clk);
    chk("ill_decode", {31'b0, illegal}, 32'd1);
    @(negedge clk);
    chk("ill_after", {31'b0, illegal}, 32'd0);
    chk("ill_next_fetch", {15'b0, mem_req, mem_addr}, 32'h0001_0001);
    wait_halted(50, "ill_halt");
    chk("ill_pulse_count", ill_cnt, 32'd1);
    chk("ill_no_rf_we", rf_we_cnt, 32'd0);
    chk("ill_no_store", st_cnt, 32'd0);
    chk("ill_fetches", fetch_log.size(), 32'd2);

    // Reset during a FETCH wait
    do_reset();
    mem_delay = 3;
    mem[0] = 16'h6205;
    start();
    @(negedge clk);
    chk("fw_waiting", {31'b0, mem_req && !mem_ready}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("fw_rst_req", {31'b0, mem_req}, 32'd0);
    chk("fw_rst_pc", {16'b0, pc}, 32'h0000);
    chk("fw_rst_rf_we", {31'b0, rf_we}, 32'd0);
    reset = 1'b0;
    mem_delay = 0;

    // Reset during WB
    do_reset();
    mem[0] = 16'h6205;
    wb_q.push_back('{3'd1, 16'h0005, 3'b000});
    start();
    begin
      int n = 0;
      while (!rf_we && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("wb_reached", {31'b0, rf_we}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("wb_rst_rf_we", {31'b0, rf_we}, 32'd0);
    chk("wb_rst_req", {31'b0, mem_req}, 32'd0);
    chk("wb_rst_pc", {16'b0, pc}, 32'h0000);
    reset = 1'b0;
    @(negedge clk);
    chk("wb_rst_idle", {31'b0, mem_req}, 32'd0);
    chk("final_wb_drained", wb_q.size(), 32'd0);
    chk("final_st_drained", st_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
